axi3_frame_mem_slave: RTL and testbench

//  AXI3 slave responder (64-bit data, 4-bit AxLEN, 6-bit IDs) backed by an on-chip 64-bit-word memory.

---
 rtl/axi3_frame_mem_slave.sv | 238 +++++++++++++++++++++++
 tb/tb_axi3_frame_mem_slave.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_frame_mem_slave.sv
// AXI3 slave (64-bit data, INCR, 8-byte beats) backed by an on-chip word memory.
// Write and read channels run independent FSMs, one outstanding burst each.
module axi3_frame_mem_slave #(
    parameter logic [31:0] BASE   = 32'h0200_0000,
    parameter int          AW_MEM = 12,
    parameter int          RD_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [3:0]  s_axi_awlen,
    input  logic [5:0]  s_axi_awid,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    output logic [5:0]  s_axi_bid,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [3:0]  s_axi_arlen,
    input  logic [5:0]  s_axi_arid,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic [5:0]  s_axi_rid
);
    localparam int DEPTH = 1 << AW_MEM;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    // Handshake rule on every channel: a transfer happens on a rising edge where valid && ready.
    function automatic logic [32:0] word_off(input logic [31:0] a);
        logic [31:0] d;
        d = (a - BASE) >> 3;
        return {1'b0, d};
    endfunction

    logic [63:0] mem_q [DEPTH];
    logic        rst_done_q;

    w_state_e            w_state_q, w_state_d;
    logic [AW_MEM-1:0]   w_idx_q, w_idx_d;
    logic [3:0]          w_len_q, w_len_d, w_beat_q, w_beat_d;
    logic [5:0]          w_id_q, w_id_d;
    logic                w_ok_q, w_ok_d, w_err_q, w_err_d;
    logic [1:0]          bresp_q, bresp_d;

    r_state_e            r_state_q, r_state_d;
    logic [AW_MEM-1:0]   r_ptr_q, r_ptr_d;
    logic [3:0]          r_len_q, r_len_d, r_beat_q, r_beat_d;
    logic [5:0]          r_id_q, r_id_d;
    logic                r_ok_q, r_ok_d;
    logic [7:0]          r_wait_q, r_wait_d;
    logic [63:0]         rdata_q;
    logic [1:0]          rresp_q;
    logic                rlast_q;

    logic [32:0]         aw_woff, ar_woff;
    logic                aw_ok, ar_ok, aw_hs, w_hs, b_hs, ar_hs, r_hs, w_err_beat;
    logic                fetch, fetch_ok, fetch_last;
    logic [AW_MEM-1:0]   fetch_idx;

    assign aw_woff = word_off(s_axi_awaddr);
    assign ar_woff = word_off(s_axi_araddr);
    assign aw_ok   = (s_axi_awaddr >= BASE) && ((aw_woff + 33'(s_axi_awlen)) < 33'(DEPTH));
    assign ar_ok   = (s_axi_araddr >= BASE) && ((ar_woff + 33'(s_axi_arlen)) < 33'(DEPTH));

    assign s_axi_awready = rst_done_q && (w_state_q == W_IDLE);
    assign s_axi_wready  = (w_state_q == W_DATA);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = w_id_q;
    assign s_axi_arready = rst_done_q && (r_state_q == R_IDLE);
    assign s_axi_rvalid  = (r_state_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = r_id_q;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign b_hs  = s_axi_bvalid && s_axi_bready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;
    assign w_err_beat = s_axi_wlast != (w_beat_q == w_len_q);

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_id_d    = w_id_q;
        w_ok_d    = w_ok_q;
        w_err_d   = w_err_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: if (aw_hs) begin
                w_state_d = W_DATA;
                w_idx_d   = aw_woff[AW_MEM-1:0];
                w_len_d   = s_axi_awlen;
                w_id_d    = s_axi_awid;
                w_ok_d    = aw_ok;
                w_beat_d  = 4'd0;
                w_err_d   = 1'b0;
            end
            W_DATA: if (w_hs) begin
                w_idx_d  = w_idx_q + 1'b1;
                w_beat_d = w_beat_q + 4'd1;
                w_err_d  = w_err_q | w_err_beat;
                // Beat count, not WLAST, ends the burst.
                if (w_beat_q == w_len_q) begin
                    w_state_d = W_RESP;
                    bresp_d   = !w_ok_q ? 2'b11 : ((w_err_q | w_err_beat) ? 2'b10 : 2'b00);
                end
            end
            W_RESP: if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d  = r_state_q;
        r_ptr_d    = r_ptr_q;
        r_len_d    = r_len_q;
        r_beat_d   = r_beat_q;
        r_id_d     = r_id_q;
        r_ok_d     = r_ok_q;
        r_wait_d   = r_wait_q;
        fetch      = 1'b0;
        fetch_idx  = r_ptr_q;
        fetch_ok   = r_ok_q;
        fetch_last = 1'b0;
        case (r_state_q)
            R_IDLE: if (ar_hs) begin
                r_ptr_d  = ar_woff[AW_MEM-1:0];
                r_len_d  = s_axi_arlen;
                r_id_d   = s_axi_arid;
                r_ok_d   = ar_ok;
                r_beat_d = 4'd0;
                r_wait_d = 8'd0;
                if (RD_LAT <= 1) begin
                    r_state_d  = R_DATA;
                    fetch      = 1'b1;
                    fetch_idx  = ar_woff[AW_MEM-1:0];
                    fetch_ok   = ar_ok;
                    fetch_last = (s_axi_arlen == 4'd0);
                end else begin
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_wait_q == 8'(RD_LAT - 2)) begin
                    r_state_d  = R_DATA;
                    fetch      = 1'b1;
                    fetch_last = (r_len_q == 4'd0);
                end else begin
                    r_wait_d = r_wait_q + 8'd1;
                end
            end
            R_DATA: if (r_hs) begin
                if (rlast_q) begin
                    r_state_d = R_IDLE;
                end else begin
                    fetch      = 1'b1;
                    r_beat_d   = r_beat_q + 4'd1;
                    fetch_last = ((r_beat_q + 4'd1) == r_len_q);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (fetch) r_ptr_d = fetch_idx + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rst_done_q <= 1'b0;
            w_state_q  <= W_IDLE;
            w_idx_q    <= '0;
            w_len_q    <= '0;
            w_beat_q   <= '0;
            w_id_q     <= '0;
            w_ok_q     <= 1'b0;
            w_err_q    <= 1'b0;
            bresp_q    <= 2'b00;
            r_state_q  <= R_IDLE;
            r_ptr_q    <= '0;
            r_len_q    <= '0;
            r_beat_q   <= '0;
            r_id_q     <= '0;
            r_ok_q     <= 1'b0;
            r_wait_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            rlast_q    <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            w_state_q  <= w_state_d;
            w_idx_q    <= w_idx_d;
            w_len_q    <= w_len_d;
            w_beat_q   <= w_beat_d;
            w_id_q     <= w_id_d;
            w_ok_q     <= w_ok_d;
            w_err_q    <= w_err_d;
            bresp_q    <= bresp_d;
            r_state_q  <= r_state_d;
            r_ptr_q    <= r_ptr_d;
            r_len_q    <= r_len_d;
            r_beat_q   <= r_beat_d;
            r_id_q     <= r_id_d;
            r_ok_q     <= r_ok_d;
            r_wait_q   <= r_wait_d;
            // A fetch on the same edge as a write to that word sees the old contents.
            if (fetch) begin
                rdata_q <= fetch_ok ? mem_q[fetch_idx] : 64'd0;
                rresp_q <= fetch_ok ? 2'b00 : 2'b11;
                rlast_q <= fetch_last;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && w_hs && w_ok_q) begin
            for (int b = 0; b < 8; b++) begin
                if (s_axi_wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi3_frame_mem_slave.sv
// Directed bench for axi3_frame_mem_slave: a word-array model feeds an expected-beat
// queue at AR time, and beats are compared as the slave presents them.
module tb_axi3_frame_mem_slave;
    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, araddr;
    logic [3:0]  awlen, arlen;
    logic [5:0]  awid, bid, arid, rid;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready, rlast;

    logic [63:0] mdl [DEPTH];
    logic [72:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    axi3_frame_mem_slave dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_awlen(awlen), .s_axi_awid(awid),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp), .s_axi_bid(bid),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_arlen(arlen), .s_axi_arid(arid),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rid(rid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic in_range(input logic [31:0] a, input logic [3:0] len);
        logic [31:0] w;
        if (a < BASE) return 1'b0;
        w = (a - BASE) >> 3;
        return ({1'b0, w} + 33'(len)) < 33'(DEPTH);
    endfunction

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id,
                               input logic [63:0] seed, input logic [7:0] strb, input int last_at,
                               input int b_stall);
        logic ok;
        logic [1:0] eresp;
        logic [31:0] widx;
        logic [11:0] mi;
        logic [63:0] d;
        int n;
        ok = in_range(addr, len);
        widx = (addr - BASE) >> 3;
        eresp = !ok ? 2'b11 : ((last_at != int'(len)) ? 2'b10 : 2'b00);
        awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("aw_ready", 96'(awready), 96'(1));
        @(negedge clk);
        awvalid = 1'b0;
        chk("w_ready_after_aw", 96'({awready, wready}), 96'(2'b01));
        for (int i = 0; i <= int'(len); i++) begin
            d = seed * 64'(i + 1);
            wvalid = 1'b1; wdata = d; wstrb = strb; wlast = (i == last_at);
            n = 0;
            while (wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            chk("w_ready", 96'(wready), 96'(1));
            @(negedge clk);
            if (ok) begin
                mi = 12'(widx + 32'(i));
                for (int b = 0; b < 8; b++) if (strb[b]) mdl[mi][8*b +: 8] = d[8*b +: 8];
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("b_valid_after_last", 96'({bvalid, wready}), 96'(2'b10));
        chk("b_fields", 96'({bid, bresp}), 96'({id, eresp}));
        for (int s = 0; s < b_stall; s++) begin
            @(negedge clk);
            chk("b_hold", 96'({bvalid, bid, bresp}), 96'({1'b1, id, eresp}));
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("b_done", 96'({bvalid, awready}), 96'(2'b01));
    endtask

    // Pushes the expected beats, performs AR, returns one cycle after the handshake.
    task automatic ar_req(input logic [31:0] addr, input logic [3:0] len, input logic [5:0] id);
        logic ok;
        logic [31:0] widx;
        logic [11:0] mi;
        int n;
        ok = in_range(addr, len);
        widx = (addr - BASE) >> 3;
        for (int i = 0; i <= int'(len); i++) begin
            mi = 12'(widx + 32'(i));
            exp_q.push_back(ok ? {2'b00, i == int'(len), id, mdl[mi]}
                               : {2'b11, i == int'(len), id, 64'd0});
        end
        araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("ar_ready", 96'(arready), 96'(1));
        @(negedge clk);
        arvalid = 1'b0;
        chk("r_not_yet", 96'({rvalid, arready}), 96'(2'b00));
    endtask

    task automatic read_drain(input int mode);
        logic pat [6];
        logic rr;
        int cyc;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            rr = (mode == 0) ? 1'b1 : pat[cyc % 6];
            rready = rr;
            chk("r_beat", 96'({rvalid, rresp, rlast, rid, rdata}), 96'({1'b1, exp_q[0]}));
            @(negedge clk);
            if (rr) void'(exp_q.pop_front());
            cyc++;
        end
        rready = 1'b0;
        chk("r_drained", 96'(exp_q.size()), 96'(0));
        chk("r_idle", 96'({rvalid, arready}), 96'(2'b01));
    endtask

    initial begin
        rst_ni = 1'b0;
        awvalid = 0; awaddr = 0; awlen = 0; awid = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arlen = 0; arid = 0; rready = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 96'({awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rlast, rid, rdata}), 96'(0));
        rst_ni = 1'b1;
        @(negedge clk);
        chk("release_ready", 96'({awready, arready, rvalid, bvalid}), 96'(4'b1100));

        // Basic 4-beat write then read, RD_LAT cycle check inside ar_req.
        write_burst(BASE, 4'd3, 6'd5, 64'h11, 8'hFF, 3, 0);
        ar_req(BASE, 4'd3, 6'd9);
        @(negedge clk);
        read_drain(0);

        // Byte strobes.
        write_burst(BASE + 32'd8, 4'd0, 6'd1, 64'h0, 8'hFF, 0, 0);
        write_burst(BASE + 32'd8, 4'd0, 6'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 0);
        chk("strobe_model", 96'(mdl[1]), 96'(64'h0000_0000_FFFF_FFFF));
        ar_req(BASE + 32'd8, 4'd0, 6'd2);
        @(negedge clk);
        read_drain(0);

        // Out-of-range write dropped; out-of-range read returns DECERR zeros.
        write_burst(BASE + 32'(8 * 4095), 4'd0, 6'd6, 64'h5A5A_A5A5_1234_8765, 8'hFF, 0, 0);
        write_burst(BASE - 32'd8, 4'd0, 6'd6, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, 0);
        ar_req(BASE + 32'(8 * 4095), 4'd0, 6'd6);
        @(negedge clk);
        read_drain(0);
        ar_req(BASE + 32'(8 * 4094), 4'd3, 6'd10);
        @(negedge clk);
        read_drain(0);

        // Early WLAST: all beats taken, SLVERR, B held while bready low.
        write_burst(BASE + 32'(8 * 16), 4'd3, 6'd12, 64'h0123_4567_89AB_CDEF, 8'hFF, 1, 5);
        ar_req(BASE + 32'(8 * 16), 4'd3, 6'd13);
        @(negedge clk);
        read_drain(0);

        // Throttled read.
        write_burst(BASE + 32'(8 * 32), 4'd7, 6'd20, 64'h1000_0000_0000_0001, 8'hFF, 7, 0);
        ar_req(BASE + 32'(8 * 32), 4'd7, 6'd21);
        @(negedge clk);
        read_drain(1);

        // Same-cycle write and read fetch of one word.
        write_burst(BASE + 32'(8 * 200), 4'd0, 6'd3, 64'hAAAA_5555_AAAA_5555, 8'hFF, 0, 0);
        awaddr = BASE + 32'(8 * 200); awlen = 4'd0; awid = 6'd3; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        chk("coll_wready", 96'(wready), 96'(1));
        ar_req(BASE + 32'(8 * 200), 4'd0, 6'd4);
        wvalid = 1'b1; wdata = 64'h0F0F_F0F0_0F0F_F0F0; wstrb = 8'hFF; wlast = 1'b1;
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
        mdl[200] = 64'h0F0F_F0F0_0F0F_F0F0;
        read_drain(0);
        chk("coll_b", 96'({bvalid, bid, bresp}), 96'({1'b1, 6'd3, 2'b00}));
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        ar_req(BASE + 32'(8 * 200), 4'd0, 6'd4);
        @(negedge clk);
        read_drain(0);

        // Reset during beat 1 of a read.
        write_burst(BASE + 32'(8 * 300), 4'd3, 6'd7, 64'h0101_0101_0101_0101, 8'hFF, 3, 0);
        ar_req(BASE + 32'(8 * 300), 4'd3, 6'd7);
        @(negedge clk);
        rready = 1'b1;
        chk("rst_beat0", 96'({rvalid, rresp, rlast, rid, rdata}), 96'({1'b1, exp_q[0]}));
        @(negedge clk);
        void'(exp_q.pop_front());
        rready = 1'b0;
        chk("rst_beat1", 96'({rvalid, rresp, rlast, rid, rdata}), 96'({1'b1, exp_q[0]}));
        rst_ni = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", 96'({awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rlast, rid, rdata}), 96'(0));
        exp_q.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        chk("rst_release", 96'({awready, arready, rvalid, bvalid, wready}), 96'(5'b11000));
        repeat (3) begin
            @(negedge clk);
            chk("no_stale_beat", 96'(rvalid), 96'(0));
        end
        rready = 1'b0;
        ar_req(BASE + 32'(8 * 301), 4'd1, 6'd8);
        @(negedge clk);
        read_drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
